// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg: tile codes, palette, colour constants and grid geometry
package minesweeper_pkg;
  localparam int TILE = 32;
  localparam int GRID_W = 16;
  localparam int GRID_H = 15;
  typedef enum logic [3:0] {
    T_EMPTY  = 4'd0,
    T_HIDDEN = 4'd9,
    T_FLAG   = 4'd10,
    T_MINE   = 4'd11,
    T_BOOM   = 4'd12
  } tile_t;
  localparam logic [7:0] C_WHITE   = 8'hFF;
  localparam logic [7:0] C_HIDDEN  = 8'hB6;
  localparam logic [7:0] C_RED     = 8'hE0;
  localparam logic [7:0] C_BLACK   = 8'h00;
  localparam logic [7:0] C_ERROR   = 8'hE3;
  localparam logic [7:0] C_EDGE    = 8'h49;
  localparam logic [7:0] C_CURSOR  = 8'hFC;
  localparam logic [7:0] C_OUTSIDE = 8'h02;
  function automatic logic [7:0] palette(input logic [3:0] code);
    case (code)
      4'd1:    return 8'h03;
      4'd2:    return 8'h1C;
      4'd3:    return 8'hE0;
      4'd4:    return 8'h02;
      4'd5:    return 8'h80;
      4'd6:    return 8'h1F;
      4'd7:    return 8'h00;
      4'd8:    return 8'h92;
      default: return C_WHITE;
    endcase
  endfunction
endpackage

// File: rtl/tile_shader.sv
// tile_shader: colour of one in-grid pixel from tile code, in-tile offset and cursor hit
module tile_shader
  import minesweeper_pkg::*;
(
  input  logic [3:0] code,
  input  logic [4:0] ox,
  input  logic [4:0] oy,
  input  logic       cursor,
  output logic [7:0] rgb
);
  logic inner, edge_px, ring;
  logic [7:0] tile;
  always_comb begin
    inner   = ox >= 5'd8 && ox <= 5'd23 && oy >= 5'd8 && oy <= 5'd23;
    edge_px = ox == 5'd0 || ox == 5'd31 || oy == 5'd0 || oy == 5'd31;
    ring    = ox < 5'd2 || ox > 5'd29 || oy < 5'd2 || oy > 5'd29;
    tile    = code == T_EMPTY  ? C_WHITE :
              code <= 4'd8     ? (inner ? palette(code) : C_WHITE) :
              code == T_HIDDEN ? C_HIDDEN :
              code == T_FLAG   ? (inner ? C_RED : C_HIDDEN) :
              code == T_MINE   ? (inner ? C_BLACK : C_WHITE) :
              code == T_BOOM   ? (inner ? C_BLACK : C_RED) : C_ERROR;
    rgb     = cursor && ring ? C_CURSOR : edge_px ? C_EDGE : tile;
  end
endmodule

// File: rtl/pixel_renderer.sv
// pixel_renderer: two-stage pixel pipeline mapping raster position to board tile colour
module pixel_renderer
  import minesweeper_pkg::*;
#(
  parameter int H_ORIGIN = 208,
  parameter int V_ORIGIN = 35
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       bright,
  input  logic       hSync,
  input  logic       vSync,
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y,
  output logic [7:0] board_addr,
  input  logic [3:0] board_data,
  output logic [7:0] rgb,
  output logic       hSync_out,
  output logic       vSync_out
);
  logic [8:0] hd, vd, hrel, vrel;
  logic [3:0] cx1, cy1;
  logic       in_grid, in_grid1, bright1, hs1, vs1, cursor;
  logic [7:0] shade, rgb_n;
  // bit 9 of the relative position never selects a tile, so only 9 bits are kept
  always_comb begin
    hd      = hCount[8:0] - 9'(H_ORIGIN);
    vd      = vCount[8:0] - 9'(V_ORIGIN);
    in_grid = int'(hCount) >= H_ORIGIN && int'(hCount) < H_ORIGIN + GRID_W * TILE &&
              int'(vCount) >= V_ORIGIN && int'(vCount) < V_ORIGIN + GRID_H * TILE;
    cursor  = hrel[8:5] == cx1 && vrel[8:5] == cy1;
    rgb_n   = !bright1 ? C_BLACK : !in_grid1 ? C_OUTSIDE : shade;
  end
  tile_shader u_shader (
    .code  (board_data),
    .ox    (hrel[4:0]),
    .oy    (vrel[4:0]),
    .cursor(cursor),
    .rgb   (shade)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hrel       <= '0;
      vrel       <= '0;
      cx1        <= '0;
      cy1        <= '0;
      in_grid1   <= 1'b0;
      bright1    <= 1'b0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      board_addr <= '0;
      rgb        <= '0;
      hSync_out  <= 1'b1;
      vSync_out  <= 1'b1;
    end else if (pix_en) begin
      hrel       <= hd;
      vrel       <= vd;
      cx1        <= cur_x;
      cy1        <= cur_y;
      in_grid1   <= in_grid;
      bright1    <= bright;
      hs1        <= hSync;
      vs1        <= vSync;
      board_addr <= {vd[8:5], hd[8:5]};
      rgb        <= rgb_n;
      hSync_out  <= hs1;
      vSync_out  <= vs1;
    end
endmodule

// File: tb/tb_pixel_renderer.sv
// tb_pixel_renderer: directed stimulus checked every cycle against a behavioural pixel model
module tb_pixel_renderer;
  logic       clk = 0, rst = 1, pix_en = 0;
  logic [9:0] hCount = 0, vCount = 0;
  logic       bright = 0, hSync = 1, vSync = 1;
  logic [3:0] cur_x = 5, cur_y = 5;
  logic [7:0] board_addr, rgb;
  logic [3:0] board_data = 0;
  logic       hSync_out, vSync_out;
  logic [3:0] board [256];
  int total = 0, bad = 0;

  typedef struct {int h; int v; bit b; bit hs; bit vs; int cx; int cy;} px_t;
  localparam logic [7:0] PAL [9] = '{8'h00, 8'h03, 8'h1C, 8'hE0, 8'h02, 8'h80, 8'h1F, 8'h00, 8'h92};

  pixel_renderer dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hCount(hCount), .vCount(vCount),
    .bright(bright), .hSync(hSync), .vSync(vSync), .cur_x(cur_x), .cur_y(cur_y),
    .board_addr(board_addr), .board_data(board_data), .rgb(rgb),
    .hSync_out(hSync_out), .vSync_out(vSync_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) board_data <= board[board_addr];

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  function automatic logic [7:0] model(input px_t p);
    int x, y, ox, oy, c;
    bit inner;
    x = p.h - 208;
    y = p.v - 35;
    if (!p.b) return 8'h00;
    if (x < 0 || x >= 512 || y < 0 || y >= 480) return 8'h02;
    ox = x % 32;
    oy = y % 32;
    c = int'(board[(y / 32) * 16 + x / 32]);
    inner = ox >= 8 && ox < 24 && oy >= 8 && oy < 24;
    if (x / 32 == p.cx && y / 32 == p.cy && (ox < 2 || ox > 29 || oy < 2 || oy > 29)) return 8'hFC;
    if (ox == 0 || ox == 31 || oy == 0 || oy == 31) return 8'h49;
    if (c == 0) return 8'hFF;
    if (c <= 8) return inner ? PAL[c] : 8'hFF;
    if (c == 9) return 8'hB6;
    if (c == 10) return inner ? 8'hE0 : 8'hB6;
    if (c == 11) return inner ? 8'h00 : 8'hFF;
    if (c == 12) return inner ? 8'h00 : 8'hE0;
    return 8'hE3;
  endfunction

  function automatic logic [7:0] eaddr(input int h, input int v);
    int col, row;
    col = (((h - 208) & 1023) >> 5) & 15;
    row = (((v - 35) & 1023) >> 5) & 15;
    return 8'(row * 16 + col);
  endfunction

  function automatic px_t mk(input int h, input int v, input int cx, input int cy);
    px_t p;
    p.h = h; p.v = v; p.b = 1; p.hs = 1; p.vs = 1; p.cx = cx; p.cy = cy;
    return p;
  endfunction

  // expected outputs trail the inputs by one pending pixel plus the output register
  px_t p1;
  logic [7:0] e_rgb, e_addr;
  bit e_hs, e_vs;
  always @(posedge clk or posedge rst)
    if (rst) begin
      p1 = mk(0, 0, 0, 0);
      p1.b = 0;
      e_rgb = 0; e_hs = 1; e_vs = 1; e_addr = 0;
    end else if (pix_en) begin
      e_rgb = model(p1);
      e_hs = p1.hs;
      e_vs = p1.vs;
      e_addr = eaddr(int'(hCount), int'(vCount));
      p1.h = int'(hCount); p1.v = int'(vCount); p1.b = bright;
      p1.hs = hSync; p1.vs = vSync; p1.cx = int'(cur_x); p1.cy = int'(cur_y);
    end

  always @(negedge clk)
    if (rst) begin
      chk("rst_rgb", rgb, 0);
      chk("rst_addr", board_addr, 0);
      chk("rst_syncs", {hSync_out, vSync_out}, 2'b11);
    end else begin
      chk("rgb", rgb, e_rgb);
      chk("addr", board_addr, e_addr);
      chk("hsync", hSync_out, e_hs);
      chk("vsync", vSync_out, e_vs);
    end

  task automatic strobe(input int h, input int v, input bit b, input bit hs, input bit vs);
    @(negedge clk);
    hCount = 10'(h); vCount = 10'(v); bright = b; hSync = hs; vSync = vs;
    pix_en = 1;
    @(negedge clk);
    pix_en = 0;
  endtask

  task automatic px(input int h, input int v);
    strobe(h, v, 1, 1, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int cnt, first;
    foreach (board[i]) board[i] = 0;
    board[0] = 9;
    board[8'h23] = 3;
    chk("m19", model(mk(208, 35, 5, 5)), 8'h49);
    chk("m20", model(mk(320, 115, 5, 5)), 8'hE0);
    chk("m21", model(mk(305, 115, 3, 2)), 8'hFC);
    chk("m22", model(mk(150, 115, 5, 5)), 8'h02);
    chk("a20", eaddr(320, 115), 8'h23);
    repeat (3) @(negedge clk);
    rst = 0;
    chk("post_rst_rgb", rgb, 8'h00);
    px(208, 35);
    chk("r19_addr", board_addr, 8'h00);
    chk("r16_rgb_first", rgb, 8'h00);
    px(209, 35);
    chk("r19_rgb", rgb, 8'h49);
    px(320, 115);
    chk("r20_addr", board_addr, 8'h23);
    px(320, 115);
    chk("r20_rgb", rgb, 8'hE0);
    cur_x = 3; cur_y = 2;
    px(305, 115);
    px(305, 115);
    chk("r21_rgb", rgb, 8'hFC);
    cur_x = 5; cur_y = 5;
    px(150, 115);
    px(150, 115);
    chk("r22_out", rgb, 8'h02);
    strobe(320, 115, 0, 1, 1);
    strobe(320, 115, 0, 1, 1);
    chk("r22_dark", rgb, 8'h00);
    cnt = 0; first = -1;
    for (int i = 0; i < 130; i++) begin
      strobe(i * 6, 600, 0, !(i >= 10 && i < 106), 1);
      if (!hSync_out) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("r22_hs_width", cnt, 96);
    chk("r22_hs_lag", first, 11);
    px(320, 115);
    px(320, 115);
    repeat (10) @(negedge clk);
    chk("r23_frozen_rgb", rgb, 8'hE0);
    chk("r23_frozen_addr", board_addr, 8'h23);
    strobe(320, 115, 1, 0, 0);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("r23_rst_rgb", rgb, 8'h00);
    chk("r23_rst_syncs", {hSync_out, vSync_out}, 2'b11);
    chk("r23_rst_addr", board_addr, 8'h00);
    repeat (2) @(negedge clk);
    rst = 0;
    px(320, 115);
    chk("r23_rec1", rgb, 8'h00);
    px(320, 115);
    chk("r23_rec2", rgb, 8'hE0);
    board[0] = 14;
    px(224, 51);
    px(224, 51);
    chk("r24_err", rgb, 8'hE3);
    board[0] = 12;
    px(224, 51);
    px(212, 39);
    chk("r24_boom_inner", rgb, 8'h00);
    px(212, 39);
    chk("r24_boom_outer", rgb, 8'hE0);
    foreach (board[i]) board[i] = 4'((i * 7 + 3) % 16);
    cur_x = 3; cur_y = 2;
    px(207, 100); px(208, 100); px(719, 100); px(720, 100);
    px(208, 34); px(208, 514); px(208, 515); px(719, 514);
    foreach (board[i]) board[i] = 4'((i * 7 + 3) % 16);
    for (int k = 0; k < 5; k++) begin
      int vv;
      vv = k == 0 ? 35 : k == 1 ? 60 : k == 2 ? 115 : k == 3 ? 514 : 99;
      for (int h = 190; h < 760; h += 9)
        strobe(h, vv, h < 740, 1, vv != 99);
    end
    px(0, 0);
    px(0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
